alu_serial_ctrl: RTL and testbench

Bit-serial sequencer for the one-bit ALU slice. It accepts a WIDTH-bit operation through a start/done handshake and feeds operand bits LSB-first into one external slice, one bit per clock. Between bits it carries the slice's carry-out forward and assembles the result word, carry-out and signed overflow. It sits between the register-file/decode logic and the single shared slice, so the slice hardware is reused for the whole word.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/piso_shift_reg.sv | 31 +++
 rtl/alu_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: operation codes, slice selects, FSM states.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;

   localparam logic [1:0] SEL_SUM = 2'd0;
   localparam logic [1:0] SEL_AND = 2'd1;
   localparam logic [1:0] SEL_OR  = 2'd2;
   localparam logic [1:0] SEL_NOT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_SUB;
   endfunction

   function automatic logic [1:0] op_sel(input logic [2:0] op);
      logic [1:0] sel;
      case (op)
         OP_AND:  sel = SEL_AND;
         OP_OR:   sel = SEL_OR;
         OP_NOT:  sel = SEL_NOT;
         default: sel = SEL_SUM;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Right-shifting register with parallel load, serial in at the MSB, serial out at the LSB.
// Single-cycle; load takes priority over shift, no backpressure.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             ser_in,
   output logic             ser_out,
   output logic [WIDTH-1:0] par_out
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {ser_in, q[WIDTH-1:1]};
      end
   end

   assign ser_out = q[0];
   assign par_out = q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a shared one-bit ALU slice: WIDTH+1 cycles from accept to done pulse.
// start is only sampled in IDLE; requests while busy are dropped, illegal ops get a one-cycle err.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [1:0]       slice_op,
   input  logic             slice_result,
   input  logic             slice_cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t          state, state_nxt;
   logic [2:0]      op_r;
   logic [CW-1:0]   cnt;
   logic            carry_r;
   logic            accept, illegal, run, last_bit, arith, is_sub;
   logic            a_ser, b_ser, res_ser;
   logic [WIDTH-1:0] a_par, b_par, res_par, res_next;
   logic            unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      illegal   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op_legal(op)) begin
                  accept    = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (cnt == LAST_BIT) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign run      = (state == ST_RUN);
   assign last_bit = run && (cnt == LAST_BIT);
   assign is_sub   = (op_r == OP_SUB);
   assign arith    = (op_r == OP_ADD) || is_sub;

   // SUB is a + ~b + 1: invert b here, the +1 comes from the preset carry.
   assign slice_a   = run & a_ser;
   assign slice_b   = run & (b_ser ^ is_sub);
   assign slice_cin = run & arith & carry_r;
   assign slice_op  = run ? op_sel(op_r) : SEL_SUM;

   assign res_next = {slice_result, res_par[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r     <= OP_ADD;
         cnt      <= '0;
         carry_r  <= 1'b0;
         err      <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         err <= illegal;
         if (accept) begin
            op_r    <= op;
            carry_r <= (op == OP_SUB);
            cnt     <= '0;
         end else if (run) begin
            cnt <= cnt + 1'b1;
            if (arith) carry_r <= slice_cout;
            if (last_bit) begin
               result   <= res_next;
               cout     <= arith & slice_cout;
               // carry_r still holds the carry into the MSB on this edge
               overflow <= arith & (carry_r ^ slice_cout);
            end
         end
      end
   end

   piso_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (a_in),
      .shift    (run),
      .ser_in   (1'b0),
      .ser_out  (a_ser),
      .par_out  (a_par)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (b_in),
      .shift    (run),
      .ser_in   (1'b0),
      .ser_out  (b_ser),
      .par_out  (b_par)
   );

   piso_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val ({WIDTH{1'b0}}),
      .shift    (run),
      .ser_in   (slice_result),
      .ser_out  (res_ser),
      .par_out  (res_par)
   );

   assign unused_bits = ^{a_par[WIDTH-1:1], b_par[WIDTH-1:1], res_par[0], res_ser};

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with a behavioural one-bit slice and an arithmetic reference model.
module tb_alu_serial_ctrl;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clk, rst_n, start;
   logic [2:0]   op;
   logic [W-1:0] a_in, b_in, result;
   logic         busy, done, err, cout, overflow;
   logic         slice_a, slice_b, slice_cin, slice_result, slice_cout;
   logic [1:0]   slice_op;

   int checks = 0;
   int errors = 0;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .a_in         (a_in),
      .b_in         (b_in),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .result       (result),
      .cout         (cout),
      .overflow     (overflow),
      .slice_a      (slice_a),
      .slice_b      (slice_b),
      .slice_cin    (slice_cin),
      .slice_op     (slice_op),
      .slice_result (slice_result),
      .slice_cout   (slice_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-bit slice: full adder carry is always produced, the sequencer must ignore it for logic ops.
   always_comb begin
      slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      case (slice_op)
         2'd0:    slice_result = slice_a ^ slice_b ^ slice_cin;
         2'd1:    slice_result = slice_a & slice_b;
         2'd2:    slice_result = slice_a | slice_b;
         default: slice_result = ~slice_a;
      endcase
   end

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         v;
      string        name;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic c, output logic v);
      logic [W:0] sum;
      res = '0; c = 1'b0; v = 1'b0;
      case (o)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[W-1:0]; c = sum[W];
            v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
         end
         OP_SUB: begin
            sum = {1'b0, a} + {1'b0, ~b} + 1;
            res = sum[W-1:0]; c = sum[W];
            v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         default: res = ~a;
      endcase
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of the cycle after done.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ev, input string name);
      int   cyc;
      logic busy_ok;
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
      cyc = 1; busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < W + 6) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({name, " latency"}, cyc, W + 1);
      chk({name, " busy_run"}, busy_ok, 1);
      chk({name, " busy_done"}, busy, 1);
      chk({name, " result"}, result, er);
      chk({name, " cout"}, cout, ec);
      chk({name, " overflow"}, overflow, ev);
      @(negedge clk);
      chk({name, " done_pulse"}, {done, busy}, 2'b00);
   endtask

   initial begin
      logic [2:0]   legal_ops[5];
      logic [2:0]   ro;
      logic [W-1:0] ra, rb, er;
      logic         ec, ev;
      int           ndone, done_cyc;

      tbl[0] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01"};
      tbl[1] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, "sub_05_07"};
      tbl[2] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "sub_80_01"};
      tbl[3] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_01"};
      tbl[4] = '{OP_AND, 8'hCA, 8'h5C, 8'h48, 1'b0, 1'b0, "and_ca_5c"};
      tbl[5] = '{OP_OR,  8'hCA, 8'h5C, 8'hDE, 1'b0, 1'b0, "or_ca_5c"};
      tbl[6] = '{OP_NOT, 8'hCA, 8'h5C, 8'h35, 1'b0, 1'b0, "not_ca"};
      legal_ops = '{OP_ADD, OP_AND, OP_OR, OP_NOT, OP_SUB};

      rst_n = 1'b0; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {busy, done, err, result, cout, overflow, slice_a, slice_b, slice_cin, slice_op}, 0);

      for (int i = 0; i < 7; i++)
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].name);

      // illegal op: err pulse, nothing else moves
      start = 1'b1; op = 3'b101; a_in = 8'h11; b_in = 8'h22;
      @(negedge clk);
      start = 1'b0; op = 3'd0;
      chk("illegal err", err, 1);
      chk("illegal busy", busy, 0);
      chk("illegal held", {result, cout, overflow}, {8'h35, 1'b0, 1'b0});
      @(negedge clk);
      chk("illegal err_pulse", {err, busy}, 2'b00);

      // start pulses during cycle 3 and during the done cycle are dropped
      start = 1'b1; op = OP_ADD; a_in = 8'h12; b_in = 8'h34;
      @(negedge clk);
      ndone = 0; done_cyc = 0;
      for (int c = 1; c <= W + 1; c++) begin
         if (done === 1'b1) begin ndone++; done_cyc = c; end
         if (c == 3 || c == W + 1) begin
            start = 1'b1; op = OP_SUB; a_in = 8'hFF; b_in = 8'h01;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
      if (done === 1'b1) ndone++;
      chk("ignore done_count", ndone, 1);
      chk("ignore done_cycle", done_cyc, W + 1);
      chk("ignore result", result, 8'h46);
      chk("ignore idle_after", busy, 0);
      do_op(OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "b2b_add");

      // asynchronous reset mid-run
      start = 1'b1; op = OP_ADD; a_in = 8'h7F; b_in = 8'h01;
      @(negedge clk);
      start = 1'b0; op = 3'd0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      chk("midrst busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst outputs", {busy, done, err, result, cout, overflow, slice_a, slice_b, slice_cin, slice_op}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, "post_rst_add");

      for (int n = 0; n < 40; n++) begin
         ro = legal_ops[$urandom_range(0, 4)];
         ra = W'($urandom);
         rb = W'($urandom);
         ref_model(ro, ra, rb, er, ec, ev);
         do_op(ro, ra, rb, er, ec, ev, $sformatf("rand%0d op%0d", n, ro));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
